// File: rtl/traffic_sink_pkg.sv
// Shared widths, state encodings and helpers for the traffic sink.
package traffic_sink_pkg;

    localparam int unsigned NUM_VC   = 4;
    localparam int unsigned VC_W     = $clog2(NUM_VC);
    localparam int unsigned ROUTER_W = 6;
    localparam int unsigned CYCLE_W  = 16;
    localparam int unsigned MAX_CD   = 8;
    localparam int unsigned CD_W     = $clog2(MAX_CD) + 1;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned SUM_W    = 32;

    localparam logic [0:0] ST_UNCFG = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    // Map an out-of-range credit delay onto 1..MAX_CD.
    function automatic logic [CD_W-1:0] clamp_delay(input logic [CD_W-1:0] d);
        if (d == '0) begin
            return CD_W'(1);
        end else if (d > CD_W'(MAX_CD)) begin
            return CD_W'(MAX_CD);
        end else begin
            return d;
        end
    endfunction

endpackage

// File: rtl/traffic_sink_credit_delay_line.sv
// Fixed-depth shift register of {valid, vc} with a runtime tap and a
// registered output, used to return credits a programmable number of cycles late.
module credit_delay_line #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned VC_W  = 2,
    parameter int unsigned TAP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [VC_W-1:0]  in_vc,
    input  logic [TAP_W-1:0] tap,
    output logic             out_valid,
    output logic [VC_W-1:0]  out_vc
);

    localparam int unsigned SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] vld_q;
    logic [VC_W-1:0]  vc_q [DEPTH];
    logic [SEL_W-1:0] sel;

    // Stage 0 holds a flit accepted at the last edge; the output register adds
    // one more cycle, so tap = d puts the credit on the wire d cycles later.
    assign sel = SEL_W'(tap - TAP_W'(1));

    // Shift the pipeline and register the selected stage; clear drops everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            out_valid <= 1'b0;
            out_vc    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                vc_q[i] <= '0;
            end
        end else if (clear) begin
            vld_q     <= '0;
            out_valid <= 1'b0;
            out_vc    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                vc_q[i] <= '0;
            end
        end else begin
            vld_q   <= {vld_q[DEPTH-2:0], in_valid};
            vc_q[0] <= in_vc;
            for (int i = 1; i < int'(DEPTH); i++) begin
                vc_q[i] <= vc_q[i-1];
            end
            out_valid <= vld_q[sel];
            out_vc    <= vc_q[sel];
        end
    end

endmodule

// File: rtl/traffic_sink.sv
// Ejection-side NoC endpoint: per-VC packet reassembly, sequencing and
// destination checks, delayed credit return and traffic statistics.
module traffic_sink
    import traffic_sink_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_load,
    input  logic [ROUTER_W-1:0] cfg_id,
    input  logic [CNT_W-1:0]    cfg_expect,
    input  logic [CD_W-1:0]     cfg_credit_delay,
    input  logic [CYCLE_W-1:0]  in_cycle,
    input  logic                flit_valid,
    input  logic                flit_head,
    input  logic                flit_tail,
    input  logic [VC_W-1:0]     flit_vc,
    input  logic [ROUTER_W-1:0] flit_dst,
    input  logic [CYCLE_W-1:0]  flit_stamp,
    output logic                cr_valid,
    output logic [VC_W-1:0]     cr_vc,
    output logic [CNT_W-1:0]    pkt_count,
    output logic [CNT_W-1:0]    flit_count,
    output logic [CNT_W-1:0]    err_count,
    output logic [SUM_W-1:0]    lat_sum,
    output logic [CYCLE_W-1:0]  lat_max,
    output logic                done
);

    logic [0:0]          state_q, state_d;
    logic [ROUTER_W-1:0] id_q, id_d;
    logic [CNT_W-1:0]    expect_q, expect_d;
    logic [CD_W-1:0]     delay_q, delay_d;
    logic [NUM_VC-1:0]   open_q, open_d;
    logic [CYCLE_W-1:0]  stamp_q [NUM_VC];
    logic [CYCLE_W-1:0]  stamp_d [NUM_VC];
    logic [CNT_W-1:0]    pkt_q, pkt_d, flit_q, flit_d, err_q, err_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [CYCLE_W-1:0]  max_q, max_d;

    logic                accept;
    logic                err;
    logic                pkt_done;
    logic [CYCLE_W-1:0]  lat;
    logic [SUM_W:0]      sum_ext;

    // Next-state: configuration load, flit sequencing and statistics.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        expect_d = expect_q;
        delay_d  = delay_q;
        open_d   = open_q;
        stamp_d  = stamp_q;
        pkt_d    = pkt_q;
        flit_d   = flit_q;
        err_d    = err_q;
        sum_d    = sum_q;
        max_d    = max_q;
        accept   = 1'b0;
        err      = 1'b0;
        pkt_done = 1'b0;
        lat      = '0;
        sum_ext  = '0;

        if (cfg_load) begin
            // Configuration wins over a flit arriving in the same cycle.
            state_d  = ST_RUN;
            id_d     = cfg_id;
            expect_d = cfg_expect;
            delay_d  = clamp_delay(cfg_credit_delay);
            open_d   = '0;
            for (int i = 0; i < int'(NUM_VC); i++) begin
                stamp_d[i] = '0;
            end
            pkt_d  = '0;
            flit_d = '0;
            err_d  = '0;
            sum_d  = '0;
            max_d  = '0;
        end else if (state_q == ST_RUN && flit_valid) begin
            accept = 1'b1;
            flit_d = flit_q + CNT_W'(1);
            err    = (flit_dst != id_q);
            if (flit_head) begin
                // A head on an open VC abandons the old packet and restarts.
                if (open_q[flit_vc]) begin
                    err = 1'b1;
                end
                if (flit_tail) begin
                    open_d[flit_vc] = 1'b0;
                    pkt_done        = 1'b1;
                    lat             = in_cycle - flit_stamp;
                end else begin
                    open_d[flit_vc]  = 1'b1;
                    stamp_d[flit_vc] = flit_stamp;
                end
            end else if (!open_q[flit_vc]) begin
                err = 1'b1;
            end else if (flit_tail) begin
                open_d[flit_vc] = 1'b0;
                pkt_done        = 1'b1;
                lat             = in_cycle - stamp_q[flit_vc];
            end

            if (err && (err_q != '1)) begin
                err_d = err_q + CNT_W'(1);
            end
            if (pkt_done) begin
                pkt_d   = pkt_q + CNT_W'(1);
                sum_ext = {1'b0, sum_q} + (SUM_W + 1)'(lat);
                sum_d   = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
                if (lat > max_q) begin
                    max_d = lat;
                end
            end
        end
    end

    // State and statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_UNCFG;
            id_q     <= '0;
            expect_q <= '0;
            delay_q  <= CD_W'(1);
            open_q   <= '0;
            for (int i = 0; i < int'(NUM_VC); i++) begin
                stamp_q[i] <= '0;
            end
            pkt_q  <= '0;
            flit_q <= '0;
            err_q  <= '0;
            sum_q  <= '0;
            max_q  <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            expect_q <= expect_d;
            delay_q  <= delay_d;
            open_q   <= open_d;
            stamp_q  <= stamp_d;
            pkt_q    <= pkt_d;
            flit_q   <= flit_d;
            err_q    <= err_d;
            sum_q    <= sum_d;
            max_q    <= max_d;
        end
    end

    credit_delay_line #(
        .DEPTH (MAX_CD),
        .VC_W  (VC_W),
        .TAP_W (CD_W)
    ) u_credit_delay_line (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (cfg_load),
        .in_valid  (accept),
        .in_vc     (flit_vc),
        .tap       (delay_q),
        .out_valid (cr_valid),
        .out_vc    (cr_vc)
    );

    assign pkt_count  = pkt_q;
    assign flit_count = flit_q;
    assign err_count  = err_q;
    assign lat_sum    = sum_q;
    assign lat_max    = max_q;
    assign done       = (state_q == ST_RUN) && (pkt_q == expect_q) && (open_q == '0);

endmodule

// File: tb/tb_traffic_sink.sv
// Directed bench for traffic_sink with a packet-level reference model and a
// per-cycle comparison of every output.
module tb_traffic_sink;
    import traffic_sink_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                cfg_load = 1'b0;
    logic [ROUTER_W-1:0] cfg_id = '0;
    logic [CNT_W-1:0]    cfg_expect = '0;
    logic [CD_W-1:0]     cfg_credit_delay = '0;
    logic [CYCLE_W-1:0]  in_cycle = '0;
    logic                flit_valid = 1'b0;
    logic                flit_head = 1'b0;
    logic                flit_tail = 1'b0;
    logic [VC_W-1:0]     flit_vc = '0;
    logic [ROUTER_W-1:0] flit_dst = '0;
    logic [CYCLE_W-1:0]  flit_stamp = '0;
    logic                cr_valid;
    logic [VC_W-1:0]     cr_vc;
    logic [CNT_W-1:0]    pkt_count, flit_count, err_count;
    logic [SUM_W-1:0]    lat_sum;
    logic [CYCLE_W-1:0]  lat_max;
    logic                done;

    traffic_sink dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_load         (cfg_load),
        .cfg_id           (cfg_id),
        .cfg_expect       (cfg_expect),
        .cfg_credit_delay (cfg_credit_delay),
        .in_cycle         (in_cycle),
        .flit_valid       (flit_valid),
        .flit_head        (flit_head),
        .flit_tail        (flit_tail),
        .flit_vc          (flit_vc),
        .flit_dst         (flit_dst),
        .flit_stamp       (flit_stamp),
        .cr_valid         (cr_valid),
        .cr_vc            (cr_vc),
        .pkt_count        (pkt_count),
        .flit_count       (flit_count),
        .err_count        (err_count),
        .lat_sum          (lat_sum),
        .lat_max          (lat_max),
        .done             (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cr_seen  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: packet-level view of the sink.
    typedef struct {
        int due;
        int vc;
    } cr_t;

    bit     m_cfg;
    int     m_id, m_expect, m_d;
    bit     m_open [NUM_VC];
    int     m_stamp [NUM_VC];
    int     m_pkt, m_flit, m_err, m_max;
    longint m_sum;
    int     edge_n = 0;
    cr_t    crq[$];

    task automatic model_clear();
        for (int i = 0; i < int'(NUM_VC); i++) begin
            m_open[i]  = 1'b0;
            m_stamp[i] = 0;
        end
        m_pkt  = 0;
        m_flit = 0;
        m_err  = 0;
        m_sum  = 0;
        m_max  = 0;
        crq.delete();
    endtask

    task automatic model_reset();
        m_cfg    = 1'b0;
        m_id     = 0;
        m_expect = 0;
        m_d      = 1;
        model_clear();
    endtask

    task automatic finish_pkt(input int stamp);
        int lat;
        lat   = (int'(in_cycle) - stamp + 65536) % 65536;
        m_pkt = (m_pkt + 1) % 65536;
        m_sum = m_sum + lat;
        if (m_sum > 64'hFFFF_FFFF) m_sum = 64'hFFFF_FFFF;
        if (lat > m_max) m_max = lat;
    endtask

    task automatic model_step();
        bit   e;
        int   v;
        cr_t  c;
        edge_n++;
        if (!rst_n) return;
        if (cfg_load) begin
            m_cfg    = 1'b1;
            m_id     = int'(cfg_id);
            m_expect = int'(cfg_expect);
            m_d      = int'(cfg_credit_delay);
            if (m_d < 1) m_d = 1;
            if (m_d > int'(MAX_CD)) m_d = int'(MAX_CD);
            model_clear();
        end else if (m_cfg && flit_valid) begin
            v      = int'(flit_vc);
            m_flit = (m_flit + 1) % 65536;
            c.due  = edge_n + m_d;
            c.vc   = v;
            crq.push_back(c);
            e = (int'(flit_dst) != m_id);
            if (flit_head) begin
                if (m_open[v]) e = 1'b1;
                if (flit_tail) begin
                    m_open[v] = 1'b0;
                    finish_pkt(int'(flit_stamp));
                end else begin
                    m_open[v]  = 1'b1;
                    m_stamp[v] = int'(flit_stamp);
                end
            end else if (!m_open[v]) begin
                e = 1'b1;
            end else if (flit_tail) begin
                m_open[v] = 1'b0;
                finish_pkt(m_stamp[v]);
            end
            if (e && m_err < 65535) m_err++;
        end
    endtask

    function automatic bit m_done();
        bit any_open = 1'b0;
        for (int i = 0; i < int'(NUM_VC); i++) any_open |= m_open[i];
        return m_cfg && (m_pkt == m_expect) && !any_open;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    initial begin
        bit exp_cr;
        forever begin
            @(negedge clk);
            exp_cr = (crq.size() > 0) && (crq[0].due == edge_n);
            chk("cr_valid", cr_valid, exp_cr);
            if (exp_cr) begin
                chk("cr_vc", cr_vc, crq[0].vc);
                void'(crq.pop_front());
            end
            if (cr_valid === 1'b1) cr_seen++;
            chk("pkt_count", pkt_count, m_pkt);
            chk("flit_count", flit_count, m_flit);
            chk("err_count", err_count, m_err);
            chk("lat_sum", lat_sum, m_sum);
            chk("lat_max", lat_max, m_max);
            chk("done", done, m_done());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flit(input bit h, input bit t, input int vc, input int dst,
                        input int stamp, input int cyc);
        flit_valid = 1'b1;
        flit_head  = h;
        flit_tail  = t;
        flit_vc    = VC_W'(vc);
        flit_dst   = ROUTER_W'(dst);
        flit_stamp = CYCLE_W'(stamp);
        in_cycle   = CYCLE_W'(cyc);
        step();
        flit_valid = 1'b0;
        flit_head  = 1'b0;
        flit_tail  = 1'b0;
    endtask

    task automatic cfg(input int id, input int expect_n, input int d, input bit with_flit);
        cfg_load         = 1'b1;
        cfg_id           = ROUTER_W'(id);
        cfg_expect       = CNT_W'(expect_n);
        cfg_credit_delay = CD_W'(d);
        if (with_flit) begin
            flit_valid = 1'b1;
            flit_head  = 1'b1;
            flit_tail  = 1'b1;
            flit_dst   = ROUTER_W'(id);
        end
        step();
        cfg_load   = 1'b0;
        flit_valid = 1'b0;
        flit_head  = 1'b0;
        flit_tail  = 1'b0;
    endtask

    initial begin
        int seen0;
        model_reset();
        step();
        step();
        chk("reset_done", done, 0);
        chk("reset_flits", flit_count, 0);
        rst_n = 1'b1;

        // Unconfigured: flit ignored.
        flit(1, 1, 0, 5, 0, 1);
        step();
        chk("uncfg_flit_count", flit_count, 0);

        // 3-flit packet on VC2, delay 3.
        cfg(5, 1, 3, 1'b0);
        chk("cfg_done_low", done, 0);
        flit(1, 0, 2, 5, 10, 18);
        flit(0, 0, 2, 5, 0, 19);
        flit(0, 1, 2, 5, 0, 20);
        chk("p1_pkt", pkt_count, 1);
        chk("p1_flit", flit_count, 3);
        chk("p1_sum", lat_sum, 10);
        chk("p1_max", lat_max, 10);
        chk("p1_done", done, 1);
        chk("p1_cr_early", cr_valid, 0);
        step();
        chk("p1_cr1", cr_valid, 1);
        chk("p1_cr1_vc", cr_vc, 2);
        step();
        chk("p1_cr2", cr_valid, 1);
        step();
        chk("p1_cr3", cr_valid, 1);
        step();
        chk("p1_cr_end", cr_valid, 0);

        // Single-flit packet with cycle wrap: latency 5.
        flit(1, 1, 0, 5, 16'hFFFE, 16'h0003);
        chk("wrap_sum", lat_sum, 15);
        chk("wrap_pkt", pkt_count, 2);
        chk("wrap_done", done, 0);

        // Body flit on a closed VC.
        flit(0, 0, 1, 5, 0, 30);
        chk("body_err", err_count, 1);
        chk("body_pkt", pkt_count, 2);
        repeat (5) step();

        // Wrong destination, delay 0 clamps to 1.
        cfg(5, 1, 0, 1'b0);
        flit(1, 1, 3, 7, 100, 104);
        chk("dst_cr_early", cr_valid, 0);
        chk("dst_err", err_count, 1);
        chk("dst_pkt", pkt_count, 1);
        chk("dst_max", lat_max, 4);
        step();
        chk("dst_cr", cr_valid, 1);
        chk("dst_cr_vc", cr_vc, 3);

        // Head on an open VC restarts the packet with the new stamp.
        flit(1, 0, 1, 5, 20, 20);
        flit(1, 0, 1, 5, 30, 31);
        flit(0, 1, 1, 5, 0, 40);
        chk("reopen_err", err_count, 2);
        chk("reopen_sum", lat_sum, 14);
        chk("reopen_max", lat_max, 10);
        step();

        // Interleaved packets, then reconfigure mid-packet (delay 9 clamps to 8).
        cfg(5, 2, 9, 1'b0);
        flit(1, 0, 0, 5, 50, 50);
        flit(1, 0, 1, 5, 51, 51);
        flit(0, 0, 0, 5, 0, 52);
        flit(0, 0, 1, 5, 0, 53);
        seen0 = cr_seen;
        cfg(5, 0, 9, 1'b1);
        chk("rcfg_flit", flit_count, 0);
        chk("rcfg_pkt", pkt_count, 0);
        chk("rcfg_done", done, 1);
        repeat (12) step();
        chk("rcfg_no_stale_cr", cr_seen - seen0, 0);

        // expect = 0, then async reset mid-run.
        cfg(5, 0, 2, 1'b0);
        chk("exp0_done", done, 1);
        flit(1, 0, 3, 5, 7, 7);
        chk("exp0_open_done", done, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_flit", flit_count, 0);
        chk("rst_done", done, 0);
        chk("rst_cr", cr_valid, 0);
        step();
        step();
        rst_n = 1'b1;
        flit(1, 1, 0, 5, 0, 9);
        repeat (3) step();
        chk("post_rst_flit", flit_count, 0);
        chk("post_rst_done", done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
